// File: rtl/life_grid_reader_if.sv
// Row-stream interface for life_grid_reader: valid/ready beats carrying one
// captured grid row, its index, and a last-row marker.
interface life_grid_reader_if #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
);
   localparam int IDX_W = ($clog2(HEIGHT) > 1) ? $clog2(HEIGHT) : 1;

   logic             row_valid;
   logic             row_ready;
   logic [WIDTH-1:0] row_data;
   logic [IDX_W-1:0] row_idx;
   logic             row_last;

   modport master (
      output row_valid,
      output row_data,
      output row_idx,
      output row_last,
      input  row_ready
   );

   modport slave (
      input  row_valid,
      input  row_data,
      input  row_idx,
      input  row_last,
      output row_ready
   );
endinterface

// File: rtl/life_grid_reader.sv
// life_grid_reader: on snap, captures the whole grid into a frame buffer and
// streams it out one row per beat over a valid/ready interface.
// Optional feature macro: LIFE_READER_POPCOUNT_EN adds live_count, the number
// of live cells in the most recently completed frame.
module life_grid_reader #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH*HEIGHT-1:0]   grid_state,
   input  logic                      snap,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      snap_overrun,
`ifdef LIFE_READER_POPCOUNT_EN
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0] live_count,
`endif
   life_grid_reader_if.master        row_if
);

   localparam int N     = WIDTH * HEIGHT;
   localparam int IDX_W = ($clog2(HEIGHT) > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     buf_q, buf_d;
   logic [WIDTH-1:0] row_data_q, row_data_d;
   logic [IDX_W-1:0] row_idx_q, row_idx_d;
   logic             row_valid_q, row_valid_d;
   logic             row_last_q, row_last_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             snap_overrun_q, snap_overrun_d;
   logic             xfer;
   logic [IDX_W-1:0] nxt_idx;
   int unsigned      nxt_base;

`ifdef LIFE_READER_POPCOUNT_EN
   localparam int CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] live_count_q, live_count_d;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int unsigned i = 0; i < WIDTH; i++) s = s + CNT_W'(v[i]);
      return s;
   endfunction
`endif

   assign xfer = row_valid_q & row_if.row_ready;

   // Next-state and next-output computation for the capture/stream FSM.
   always_comb begin
      state_d        = state_q;
      buf_d          = buf_q;
      row_data_d     = row_data_q;
      row_idx_d      = row_idx_q;
      row_valid_d    = row_valid_q;
      row_last_d     = row_last_q;
      busy_d         = busy_q;
      frame_done_d   = 1'b0;
      snap_overrun_d = snap_overrun_q;
      nxt_idx        = row_idx_q + IDX_W'(1);
      nxt_base       = 0;
`ifdef LIFE_READER_POPCOUNT_EN
      acc_d          = acc_q;
      live_count_d   = live_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (snap) begin
               buf_d       = grid_state;
               state_d     = SEND;
               row_valid_d = 1'b1;
               row_idx_d   = '0;
               row_data_d  = grid_state[WIDTH-1:0];
               row_last_d  = 1'b0;
               busy_d      = 1'b1;
`ifdef LIFE_READER_POPCOUNT_EN
               acc_d       = '0;
`endif
            end
         end
         SEND: begin
            if (snap) snap_overrun_d = 1'b1;
            if (xfer) begin
               if (row_last_q) begin
                  state_d      = IDLE;
                  row_valid_d  = 1'b0;
                  row_idx_d    = '0;
                  row_data_d   = '0;
                  row_last_d   = 1'b0;
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
`ifdef LIFE_READER_POPCOUNT_EN
                  live_count_d = acc_q + popcount(row_data_q);
`endif
               end else begin
                  nxt_base   = int'(nxt_idx) * WIDTH;
                  row_idx_d  = nxt_idx;
                  row_data_d = buf_q[nxt_base +: WIDTH];
                  row_last_d = (nxt_idx == IDX_W'(HEIGHT - 1));
`ifdef LIFE_READER_POPCOUNT_EN
                  acc_d      = acc_q + popcount(row_data_q);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, asynchronously cleared by active-low rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         buf_q          <= '0;
         row_data_q     <= '0;
         row_idx_q      <= '0;
         row_valid_q    <= 1'b0;
         row_last_q     <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         snap_overrun_q <= 1'b0;
`ifdef LIFE_READER_POPCOUNT_EN
         acc_q          <= '0;
         live_count_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         buf_q          <= buf_d;
         row_data_q     <= row_data_d;
         row_idx_q      <= row_idx_d;
         row_valid_q    <= row_valid_d;
         row_last_q     <= row_last_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         snap_overrun_q <= snap_overrun_d;
`ifdef LIFE_READER_POPCOUNT_EN
         acc_q          <= acc_d;
         live_count_q   <= live_count_d;
`endif
      end
   end

   assign row_if.row_valid = row_valid_q;
   assign row_if.row_data  = row_data_q;
   assign row_if.row_idx   = row_idx_q;
   assign row_if.row_last  = row_last_q;
   assign busy             = busy_q;
   assign frame_done       = frame_done_q;
   assign snap_overrun     = snap_overrun_q;
`ifdef LIFE_READER_POPCOUNT_EN
   assign live_count       = live_count_q;
`endif

endmodule

// File: tb/tb_life_grid_reader.sv
// Testbench for life_grid_reader (8x8 grid). Expected rows come from shifting
// the captured 64-bit grid; expected live counts from $countones.
// Build with LIFE_READER_POPCOUNT_EN defined to also exercise live_count.
module tb_life_grid_reader;
   localparam int W = 8;
   localparam int H = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          snap;
   logic [63:0]   grid_state;
   logic          busy, frame_done, snap_overrun;
`ifdef LIFE_READER_POPCOUNT_EN
   logic [6:0]    live_count;
`endif

   life_grid_reader_if #(.WIDTH(W), .HEIGHT(H)) row_if ();

   life_grid_reader #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk          (clk),
      .rst          (rst),
      .grid_state   (grid_state),
      .snap         (snap),
      .busy         (busy),
      .frame_done   (frame_done),
      .snap_overrun (snap_overrun),
`ifdef LIFE_READER_POPCOUNT_EN
      .live_count   (live_count),
`endif
      .row_if       (row_if)
   );

   always #5 clk = ~clk;

   int assertions = 0;
   int failures   = 0;

   // Beats observed by collect()
   logic [W-1:0] bd[$];
   int           bi[$];
   bit           bl[$];
   int           c_stall_err, c_valid_cyc, c_early_done;
   bit           c_timeout, c_done, c_first_valid, c_done_busy, c_done_valid, c_done_ovr;
   logic [W-1:0] c_done_data;
   int           c_live, c_first_live;

   function automatic logic [W-1:0] exp_row(input logic [63:0] g, input int r);
      return W'(g >> (r * W));
   endfunction

   task automatic do_snap(input logic [63:0] g, input bit scramble);
      @(negedge clk);
      grid_state = g;
      snap = 1'b1;
      @(posedge clk);
      #1 snap = 1'b0;
      if (scramble) grid_state = '1;
   endtask

   // Drives row_ready and records beats until the cycle after the last beat.
   task automatic collect(input int mode, input int snap_row, input int abort_row, input bit b2b);
      int cyc = 0;
      bit got_last = 0, prev_stall = 0, snapped = 0, snap_used = 0, rdy;
      logic [W-1:0] pd = '0;
      int pi = 0;
      bit pl = 0;
      bd.delete(); bi.delete(); bl.delete();
      c_stall_err = 0; c_valid_cyc = 0; c_early_done = 0;
      c_timeout = 0; c_done = 0; c_first_valid = 0; c_done_busy = 1; c_done_valid = 1;
      c_done_ovr = 0; c_done_data = '1; c_live = -1; c_first_live = -1;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (snapped) begin snap = 1'b0; snapped = 0; end
         if (got_last) begin
            c_done       = (frame_done === 1'b1);
            c_done_busy  = busy;
            c_done_valid = row_if.row_valid;
            c_done_data  = row_if.row_data;
            c_done_ovr   = snap_overrun;
`ifdef LIFE_READER_POPCOUNT_EN
            c_live = int'(live_count);
`endif
            if (b2b) snap = 1'b1;
            return;
         end
         if (cyc == 1) begin
            c_first_valid = (row_if.row_valid === 1'b1) && (busy === 1'b1);
`ifdef LIFE_READER_POPCOUNT_EN
            c_first_live = int'(live_count);
`endif
         end
         if (frame_done !== 1'b0) c_early_done++;
         if (prev_stall && (row_if.row_valid !== 1'b1 || row_if.row_data !== pd ||
                            int'(row_if.row_idx) != pi || row_if.row_last !== pl))
            c_stall_err++;
         if (abort_row >= 0 && row_if.row_valid && int'(row_if.row_idx) == abort_row) begin
            row_if.row_ready = 1'b0;
            return;
         end
         if (snap_row >= 0 && !snap_used && row_if.row_valid && int'(row_if.row_idx) == snap_row) begin
            snap = 1'b1; snapped = 1; snap_used = 1;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (c_valid_cyc % 4 == 0) || (c_valid_cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         row_if.row_ready = rdy;
         if (row_if.row_valid === 1'b1) begin
            c_valid_cyc++;
            if (rdy) begin
               bd.push_back(row_if.row_data);
               bi.push_back(int'(row_if.row_idx));
               bl.push_back(row_if.row_last);
               if (bd.size() == H) got_last = 1;
            end
         end
         prev_stall = (row_if.row_valid === 1'b1) && !rdy;
         pd = row_if.row_data; pi = int'(row_if.row_idx); pl = row_if.row_last;
      end
      c_timeout = 1;
   endtask

   task automatic test_reset();
      rst = 1'b0; snap = 1'b0; grid_state = '0; row_if.row_ready = 1'b0;
      #1;
      assertions++;
      if ({row_if.row_valid, row_if.row_last, busy, frame_done, snap_overrun} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {row_if.row_valid, row_if.row_last, busy, frame_done, snap_overrun});
      end
      assertions++;
      if (row_if.row_data !== '0 || row_if.row_idx !== '0) begin
         failures++;
         $display("FAIL reset_data_idx: got %h/%0d expected 0/0", row_if.row_data, row_if.row_idx);
      end
`ifdef LIFE_READER_POPCOUNT_EN
      assertions++;
      if (live_count !== '0) begin
         failures++; $display("FAIL reset_live: got %0d expected 0", live_count);
      end
`endif
      grid_state = 64'hFFFF; snap = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
      @(negedge clk);
      snap = 1'b0; rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [63:0] g = 64'h0102_0408_1020_4080;
      do_snap(g, 0);
      collect(0, -1, -1, 0);
      assertions++;
      if (!c_first_valid) begin failures++; $display("FAIL basic_latency: got 0 expected 1"); end
      assertions++;
      if (c_timeout || bd.size() != H) begin
         failures++; $display("FAIL basic_beats: got %0d expected %0d", bd.size(), H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g, r) || bi[r] != r || bl[r] != (r == H - 1)) begin
            failures++;
            $display("FAIL basic_row%0d: got %h/%0d/%b expected %h/%0d/%b",
                     r, bd[r], bi[r], bl[r], exp_row(g, r), r, (r == H - 1));
         end
      end
      assertions++;
      if (c_valid_cyc != H) begin
         failures++; $display("FAIL basic_valid_cycles: got %0d expected %0d", c_valid_cyc, H);
      end
      assertions++;
      if (!c_done || c_early_done != 0) begin
         failures++; $display("FAIL basic_done: got %b/%0d expected 1/0", c_done, c_early_done);
      end
      assertions++;
      if (c_done_busy !== 1'b0 || c_done_valid !== 1'b0 || c_done_data !== '0) begin
         failures++;
         $display("FAIL basic_idle_outputs: got %b/%b/%h expected 0/0/00", c_done_busy, c_done_valid, c_done_data);
      end
      @(negedge clk);
      assertions++;
      if (frame_done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b expected 0", frame_done); end
   endtask

   task automatic test_backpressure();
      logic [63:0] g = {$urandom, $urandom};
      do_snap(g, 0);
      collect(1, -1, -1, 0);
      assertions++;
      if (c_timeout || bd.size() != H) begin
         failures++; $display("FAIL bp_beats: got %0d expected %0d", bd.size(), H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g, r) || bi[r] != r) begin
            failures++; $display("FAIL bp_row%0d: got %h/%0d expected %h/%0d", r, bd[r], bi[r], exp_row(g, r), r);
         end
      end
      assertions++;
      if (c_stall_err != 0) begin failures++; $display("FAIL bp_stall_stable: got %0d expected 0", c_stall_err); end
      assertions++;
      if (c_valid_cyc != 16 || !c_done) begin
         failures++; $display("FAIL bp_valid_cycles: got %0d/%b expected 16/1", c_valid_cyc, c_done);
      end
   endtask

   task automatic test_isolation();
      logic [63:0] g = 64'h0123_4567_89AB_CDEF;
      do_snap(g, 1);
      collect(2, -1, -1, 0);
      assertions++;
      if (c_timeout || bd.size() != H || !c_done) begin
         failures++; $display("FAIL iso_beats: got %0d/%b expected %0d/1", bd.size(), c_done, H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g, r)) begin
            failures++; $display("FAIL iso_row%0d: got %h expected %h", r, bd[r], exp_row(g, r));
         end
      end
      grid_state = '0;
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         logic [63:0] g = {$urandom, $urandom};
         do_snap(g, 1);
         collect(2, -1, -1, 0);
         assertions++;
         if (c_timeout || bd.size() != H || !c_done || c_stall_err != 0 || c_early_done != 0) begin
            failures++;
            $display("FAIL rand%0d_frame: got beats %0d done %b stall %0d early %0d expected %0d/1/0/0",
                     f, bd.size(), c_done, c_stall_err, c_early_done, H);
         end
         for (int r = 0; r < bd.size(); r++) begin
            assertions++;
            if (bd[r] !== exp_row(g, r) || bi[r] != r || bl[r] != (r == H - 1)) begin
               failures++; $display("FAIL rand%0d_row%0d: got %h/%0d expected %h/%0d", f, r, bd[r], bi[r], exp_row(g, r), r);
            end
         end
`ifdef LIFE_READER_POPCOUNT_EN
         assertions++;
         if (c_live != $countones(g)) begin
            failures++; $display("FAIL rand%0d_live: got %0d expected %0d", f, c_live, $countones(g));
         end
`endif
      end
      assertions++;
      if (snap_overrun !== 1'b0) begin failures++; $display("FAIL rand_no_overrun: got %b expected 0", snap_overrun); end
   endtask

   task automatic test_overrun_b2b();
      logic [63:0] g1 = {$urandom, $urandom};
      logic [63:0] g2 = ~g1;
      do_snap(g1, 0);
      grid_state = g2;
      collect(0, 3, -1, 1);
      assertions++;
      if (c_timeout || bd.size() != H || !c_done) begin
         failures++; $display("FAIL ovr_frame: got %0d/%b expected %0d/1", bd.size(), c_done, H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g1, r)) begin
            failures++; $display("FAIL ovr_row%0d: got %h expected %h", r, bd[r], exp_row(g1, r));
         end
      end
      assertions++;
      if (c_done_ovr !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", c_done_ovr); end
      @(posedge clk);
      #1 snap = 1'b0;
      collect(0, -1, -1, 0);
      assertions++;
      if (!c_first_valid) begin failures++; $display("FAIL b2b_start: got 0 expected 1"); end
      assertions++;
      if (c_timeout || bd.size() != H || !c_done) begin
         failures++; $display("FAIL b2b_frame: got %0d/%b expected %0d/1", bd.size(), c_done, H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g2, r)) begin
            failures++; $display("FAIL b2b_row%0d: got %h expected %h", r, bd[r], exp_row(g2, r));
         end
      end
      assertions++;
      if (snap_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", snap_overrun); end
   endtask

   task automatic test_reset_midframe();
      logic [63:0] g1 = {$urandom, $urandom};
      logic [63:0] g2 = {$urandom, $urandom};
      int dones = 0;
      do_snap(g1, 0);
      collect(0, 2, 5, 0);
      #2;
      assertions++;
      if (snap_overrun !== 1'b1 || row_if.row_idx !== 3'd5) begin
         failures++; $display("FAIL mid_before: got %b/%0d expected 1/5", snap_overrun, row_if.row_idx);
      end
      rst = 1'b0;
      #1;
      assertions++;
      if ({row_if.row_valid, row_if.row_last, busy, frame_done, snap_overrun} !== 5'b0 ||
          row_if.row_data !== '0 || row_if.row_idx !== '0) begin
         failures++;
         $display("FAIL mid_async_clear: got %b %h %0d expected 00000 00 0",
                  {row_if.row_valid, row_if.row_last, busy, frame_done, snap_overrun}, row_if.row_data, row_if.row_idx);
      end
`ifdef LIFE_READER_POPCOUNT_EN
      assertions++;
      if (live_count !== '0) begin failures++; $display("FAIL mid_live_clear: got %0d expected 0", live_count); end
`endif
      row_if.row_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (frame_done !== 1'b0) dones++;
      end
      rst = 1'b1; grid_state = g2; snap = 1'b1;
      @(posedge clk);
      #1 snap = 1'b0;
      collect(0, -1, -1, 0);
      assertions++;
      if (dones != 0 || c_early_done != 0) begin
         failures++; $display("FAIL mid_no_done: got %0d expected 0", dones + c_early_done);
      end
      assertions++;
      if (!c_first_valid || bd.size() != H || !c_done) begin
         failures++; $display("FAIL mid_restart: got %b/%0d/%b expected 1/%0d/1", c_first_valid, bd.size(), c_done, H);
      end
      for (int r = 0; r < bd.size(); r++) begin
         assertions++;
         if (bd[r] !== exp_row(g2, r) || bi[r] != r) begin
            failures++; $display("FAIL mid_row%0d: got %h/%0d expected %h/%0d", r, bd[r], bi[r], exp_row(g2, r), r);
         end
      end
   endtask

`ifdef LIFE_READER_POPCOUNT_EN
   task automatic test_popcount();
      logic [63:0] glider = 64'h0000_0000_0007_0402;
      do_snap(glider, 0);
      collect(2, -1, -1, 0);
      assertions++;
      if (!c_done || c_live != 5) begin
         failures++; $display("FAIL pop_glider: got %0d/%b expected 5/1", c_live, c_done);
      end
      repeat (3) @(negedge clk);
      assertions++;
      if (live_count !== 7'd5) begin failures++; $display("FAIL pop_hold: got %0d expected 5", live_count); end
      do_snap('1, 0);
      collect(1, -1, -1, 0);
      assertions++;
      if (c_first_live != 5) begin failures++; $display("FAIL pop_hold_stream: got %0d expected 5", c_first_live); end
      assertions++;
      if (!c_done || c_live != 64) begin
         failures++; $display("FAIL pop_full: got %0d/%b expected 64/1", c_live, c_done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_isolation();
      test_random();
      test_overrun_b2b();
      test_reset_midframe();
`ifdef LIFE_READER_POPCOUNT_EN
      test_popcount();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule

// File: doc/life_grid_reader.md
LIFE_GRID_READER -- requirements
Module: life_grid_reader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the cells per grid row.
REQ-002 The module SHALL have parameter HEIGHT, default 8, giving the rows per grid; HEIGHT >= 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 grid_state  input  WIDTH*HEIGHT  live cell states; cell (r,c) is bit r*WIDTH+c.
REQ-006 snap  input  1  request to capture and stream one frame.
REQ-007 busy  output  1  high while a frame is held or streaming.
REQ-008 row_valid  output  1  row beat available.
REQ-009 row_ready  input  1  consumer accepts the beat.
REQ-010 row_data  output  WIDTH  captured row contents.
REQ-011 row_idx  output  max(1,$clog2(HEIGHT))  index of the current row.
REQ-012 row_last  output  1  high with the beat for row HEIGHT-1.
REQ-013 frame_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-014 snap_overrun  output  1  sticky flag for a snap received while busy.

Function
REQ-015 The FSM SHALL have two states, IDLE and SEND.
REQ-016 In IDLE with snap=1, the module SHALL copy grid_state into an internal frame buffer on that edge and enter SEND with row_idx=0.
REQ-017 Latency: the first beat's row_valid SHALL be high in the cycle after the snap edge.
REQ-018 In SEND, row_valid=1 and row_data = buffer[row_idx*WIDTH +: WIDTH].
REQ-019 Changes on grid_state after capture SHALL NOT affect the frame being streamed.
REQ-020 A beat transfers on a rising edge with row_valid=1 and row_ready=1.
REQ-021 While row_valid=1 and row_ready=0, row_data, row_idx and row_last SHALL stay stable.
REQ-022 On a transfer with row_idx < HEIGHT-1, row_idx SHALL increment by 1 and the FSM SHALL stay in SEND.
REQ-023 row_last SHALL equal (row_idx == HEIGHT-1) while in SEND.
REQ-024 On a transfer of the last row, the FSM SHALL return to IDLE, row_idx SHALL clear to 0, and frame_done SHALL be high for exactly the next cycle.
REQ-025 busy SHALL equal (state == SEND).
REQ-026 A snap in SEND SHALL be ignored and SHALL set snap_overrun.
REQ-027 snap_overrun SHALL clear only on reset.
REQ-028 A snap in the cycle where frame_done is high (IDLE) SHALL start a new frame, giving back-to-back frames with one idle cycle between them.
REQ-029 With row_ready held high, a frame SHALL take exactly HEIGHT cycles of row_valid.
REQ-030 In IDLE, row_valid, row_last and busy SHALL be 0, and row_data SHALL be 0.

Reset
REQ-031 Asserting rst at any time SHALL asynchronously force the following: state IDLE, row_valid 0, row_idx 0, row_last 0, row_data 0, busy 0, frame_done 0, snap_overrun 0, frame buffer 0, live_count 0.
REQ-032 A frame interrupted by reset SHALL be discarded; no frame_done SHALL be issued for it.
REQ-033 After rst deasserts, the module SHALL accept snap on the first rising edge.

Configuration
REQ-034 Macro LIFE_READER_POPCOUNT_EN, when defined, SHALL add the output live_count [$clog2(WIDTH*HEIGHT+1)-1:0].
REQ-035 With LIFE_READER_POPCOUNT_EN defined, an accumulator SHALL clear on capture and add popcount(row_data) on each transfer.
REQ-036 With LIFE_READER_POPCOUNT_EN defined, live_count SHALL be updated to the frame total in the same cycle frame_done is high, and hold until the next frame completes.
REQ-037 Without LIFE_READER_POPCOUNT_EN, the port, accumulator and popcount logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-038 Basic stream: WIDTH=HEIGHT=8, grid_state=64'h0102_0408_1020_4080, snap pulse, row_ready=1 -> 8 beats, row_data 8'h80,8'h40,...,8'h01 for row_idx 0..7, row_last only on row 7, frame_done one cycle after.
REQ-039 Backpressure: row_ready toggling 1,0,0,1 -> row_data and row_idx held during stalls, no beat lost or duplicated, frame still 8 beats.
REQ-040 Snapshot isolation: grid_state changed to all-ones after the snap edge -> streamed rows match the pre-change value.
REQ-041 Overrun and back-to-back: snap during row 3 -> ignored, snap_overrun=1. Then snap in the frame_done cycle -> a second frame starts the next cycle.
REQ-042 Reset mid-frame: rst low during row 5 -> all outputs 0 immediately, no frame_done, snap_overrun cleared. A new snap after release streams from row 0.
REQ-043 Popcount (macro defined): glider pattern with 5 live cells -> live_count=5 with frame_done; all-ones 8x8 grid -> live_count=64.
